hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage risc_v core (F/D/E/M/W).
- Keeps its own shadow copy of the register-address and control fields as they move through stages E, M and W.
- From that state it drives the forwarding selects, the stall and flush controls, and a wait state that freezes the pipeline while the data memory is busy.
- Sits beside the pipeline registers. Every pipeline-register enable and clear in risc_v comes from this block.

---
 rtl/hazard_ctrl.sv | 239 +++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the 5-stage risc_v core.
//
// Keeps a shadow copy of the register-address and control fields of the
// instructions in Execute, Memory and Writeback. From that copy it derives
// the operand forwarding selects, the load-use stall, the control-hazard
// flush, and a freeze that holds the pipeline while data memory is busy.
// Every pipeline-register enable and clear in the core comes from here, so
// the shadow stages step with exactly the stall/flush values driven out.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   Rs1D, Rs2D, RdD     register addresses of the instruction in Decode
//   RegWriteD           Decode instruction writes the register file
//   ResultSrcD          Decode result select (01 = load)
//   MemWriteD           Decode instruction is a store
//   PCSrcE              taken branch / jump resolved in Execute
//   mem_ready           data memory finished the access of the M instruction
//   StallF..StallM      hold PC, F/D, D/E, E/M registers
//   FlushD, FlushE      clear F/D, D/E registers
//   FlushW              clear M/W register (bubble into Writeback)
//   ForwardAE/BE        ALU operand select: 00 regfile, 01 ResultW, 10 ALUResultM
//   mem_err             sticky: a data-memory wait was force-released
//   stall_cnt           saturating count of cycles with StallF=1
//
// Handshake: mem_ready is level-sensitive. While the instruction in Memory
// accesses memory and mem_ready is low, the pipeline is frozen; the cycle in
// which mem_ready is seen high is the cycle the pipeline advances again.

module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 15,
  parameter int PERF_WIDTH     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] RdD,
  input  logic                      RegWriteD,
  input  logic [1:0]                ResultSrcD,
  input  logic                      MemWriteD,
  input  logic                      PCSrcE,
  input  logic                      mem_ready,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      mem_err,
  output logic [PERF_WIDTH-1:0]     stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t state, state_next;
  logic [WAIT_W-1:0] wait_cnt;

  // Shadow Execute stage
  logic [REG_ADDR_WIDTH-1:0] rs1_e, rs2_e, rd_e;
  logic                      reg_write_e;
  logic [1:0]                result_src_e;
  logic                      mem_access_e;

  // Shadow Memory stage. The result select is not kept here: nothing
  // downstream of Execute depends on it for hazard decisions.
  logic [REG_ADDR_WIDTH-1:0] rd_m;
  logic                      reg_write_m;
  logic                      mem_access_m;

  // Shadow Writeback stage
  logic [REG_ADDR_WIDTH-1:0] rd_w;
  logic                      reg_write_w;

  logic mem_access_d;
  logic timeout_hit;
  logic mem_release;
  logic freeze;
  logic load_use;

  assign mem_access_d = MemWriteD | (ResultSrcD == 2'b01);

  // Counter reaching the limit only matters while waiting.
  assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == WAIT_LIMIT);
  assign mem_release = mem_ready | timeout_hit;

  // The memory term is qualified with RUN so that a forced release in
  // MEM_WAIT is not immediately re-frozen by the same stuck access.
  assign freeze = ((state == RUN) && mem_access_m && !mem_ready) ||
                  ((state == MEM_WAIT) && !mem_release);

  assign load_use = (result_src_e == 2'b01) && (rd_e != '0) &&
                    ((rd_e == Rs1D) || (rd_e == Rs2D));

  // ---------------------------------------------------------------------
  // Next state and stall/flush controls
  // ---------------------------------------------------------------------
  always_comb begin
    state_next = state;
    StallF     = 1'b0;
    StallD     = 1'b0;
    StallE     = 1'b0;
    StallM     = 1'b0;
    FlushD     = 1'b0;
    FlushE     = 1'b0;
    FlushW     = 1'b0;

    case (state)
      RUN:      if (mem_access_m && !mem_ready) state_next = MEM_WAIT;
      MEM_WAIT: if (mem_release)                state_next = RUN;
      default:                                  state_next = RUN;
    endcase

    if (!rst) begin
      if (freeze) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        FlushW = 1'b1;
      end else if (PCSrcE) begin
        // Wrong-path instructions in D and E are discarded; any load-use
        // stall on the wrong-path Decode instruction is moot.
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Forwarding selects; x0 is never forwarded, M has priority over W
  // ---------------------------------------------------------------------
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (!rst) begin
      if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
        ForwardAE = 2'b10;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
        ForwardAE = 2'b01;

      if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
        ForwardBE = 2'b10;
      else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
        ForwardBE = 2'b01;
    end
  end

  // ---------------------------------------------------------------------
  // FSM state, wait counter, error flag, performance counter
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_next;

      if ((state == MEM_WAIT) && !mem_release)
        wait_cnt <= wait_cnt + WAIT_W'(1);
      else
        wait_cnt <= '0;

      if (timeout_hit && !mem_ready)
        mem_err <= 1'b1;

      if (StallF && (stall_cnt != {PERF_WIDTH{1'b1}}))
        stall_cnt <= stall_cnt + PERF_WIDTH'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Shadow pipeline
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_e        <= '0;
      rs2_e        <= '0;
      rd_e         <= '0;
      reg_write_e  <= 1'b0;
      result_src_e <= 2'b00;
      mem_access_e <= 1'b0;
      rd_m         <= '0;
      reg_write_m  <= 1'b0;
      mem_access_m <= 1'b0;
      rd_w         <= '0;
      reg_write_w  <= 1'b0;
    end else begin
      // D -> E
      if (FlushE) begin
        rs1_e        <= '0;
        rs2_e        <= '0;
        rd_e         <= '0;
        reg_write_e  <= 1'b0;
        result_src_e <= 2'b00;
        mem_access_e <= 1'b0;
      end else if (!StallE) begin
        rs1_e        <= Rs1D;
        rs2_e        <= Rs2D;
        rd_e         <= RdD;
        reg_write_e  <= RegWriteD;
        result_src_e <= ResultSrcD;
        mem_access_e <= mem_access_d;
      end

      // E -> M
      if (!StallM) begin
        rd_m         <= rd_e;
        reg_write_m  <= reg_write_e;
        mem_access_m <= mem_access_e;
      end

      // M -> W
      if (FlushW) begin
        rd_w        <= '0;
        reg_write_w <= 1'b0;
      end else begin
        rd_w        <= rd_m;
        reg_write_w <= reg_write_m;
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 ns later, and state advances on the rising edge.

module tb_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       RegWriteD;
  logic [1:0] ResultSrcD;
  logic       MemWriteD;
  logic       PCSrcE;
  logic       mem_ready;
  logic       StallF, StallD, StallE, StallM;
  logic       FlushD, FlushE, FlushW;
  logic [1:0] ForwardAE, ForwardBE;
  logic       mem_err;
  logic [15:0] stall_cnt;

  logic [6:0] ctrl;
  assign ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_FRZ  = 7'b1111001;
  localparam logic [6:0] C_LU   = 7'b1100010;
  localparam logic [6:0] C_CH   = 7'b0000110;

  int pass_cnt  = 0;
  int total_cnt = 0;

  hazard_ctrl #(
    .REG_ADDR_WIDTH(5),
    .MEM_TIMEOUT(15),
    .PERF_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .MemWriteD(MemWriteD),
    .PCSrcE(PCSrcE), .mem_ready(mem_ready),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // One cycle: new Decode-side inputs at the falling edge, settle 1 ns.
  task automatic step(input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic rw,
                      input logic [1:0] rsrc, input logic mw,
                      input logic pc, input logic mr);
    @(negedge clk);
    Rs1D = rs1; Rs2D = rs2; RdD = rd;
    RegWriteD = rw; ResultSrcD = rsrc; MemWriteD = mw;
    PCSrcE = pc; mem_ready = mr;
    #1;
  endtask

  task automatic bubble(input logic pc, input logic mr);
    step(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, pc, mr);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0;
    PCSrcE = 1'b0; mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    Rs1D = 5'd3; Rs2D = 5'd4; RdD = 5'd3;
    RegWriteD = 1'b1; ResultSrcD = 2'b01; MemWriteD = 1'b1;
    PCSrcE = 1'b1; mem_ready = 1'b0;
    #1;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL rst_ctrl got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b0000)
      $display("FAIL rst_fwd got=%b exp=0000", {ForwardAE, ForwardBE});
    else pass_cnt++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (mem_err !== 1'b0) $display("FAIL reset_mem_err got=%b exp=0", mem_err);
    else pass_cnt++;
  endtask

  task automatic test_forward;
    do_reset();
    step(5'd0, 5'd0, 5'd5, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1); // A: writes x5
    step(5'd5, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); // B: rs1=x5
    step(5'd0, 5'd5, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); // C: rs2=x5
    // E=B, M=A
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b1000)
      $display("FAIL fwd_m_rs1 got=%b exp=1000", {ForwardAE, ForwardBE});
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    // E=C, M=B, W=A
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b0001)
      $display("FAIL fwd_w_rs2 got=%b exp=0001", {ForwardAE, ForwardBE});
    else pass_cnt++;
    // M has priority over W
    step(5'd0, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    step(5'd0, 5'd0, 5'd9, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
    step(5'd9, 5'd9, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    bubble(1'b0, 1'b1);
    total_cnt++;
    if ({ForwardAE, ForwardBE} !== 4'b1010)
      $display("FAIL fwd_m_priority got=%b exp=1010", {ForwardAE, ForwardBE});
    else pass_cnt++;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL fwd_ctrl got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
  endtask

  task automatic test_load_use;
    do_reset();
    step(5'd0, 5'd0, 5'd6, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1); // lw x6
    step(5'd0, 5'd6, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); // uses x6
    total_cnt++;
    if (ctrl !== C_LU) $display("FAIL load_use_stall got=%b exp=%b", ctrl, C_LU);
    else pass_cnt++;
    step(5'd0, 5'd6, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); // held in D
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL load_use_one_cycle got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (ForwardBE !== 2'b01) $display("FAIL load_use_fwd got=%b exp=01", ForwardBE);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd1) $display("FAIL load_use_cnt got=%0d exp=1", stall_cnt);
    else pass_cnt++;
  endtask

  task automatic test_load_x0;
    do_reset();
    step(5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1); // lw x0
    step(5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1); // rs1=x0
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL load_x0_no_stall got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (ForwardAE !== 2'b00) $display("FAIL load_x0_fwd_m got=%b exp=00", ForwardAE);
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (ForwardAE !== 2'b00) $display("FAIL load_x0_fwd_w got=%b exp=00", ForwardAE);
    else pass_cnt++;
  endtask

  task automatic test_branch_over_load_use;
    do_reset();
    step(5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1); // lw x7
    step(5'd7, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 1'b1, 1'b1); // uses x7, branch taken
    total_cnt++;
    if (ctrl !== C_CH) $display("FAIL branch_flush got=%b exp=%b", ctrl, C_CH);
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (stall_cnt !== 16'd0) $display("FAIL branch_cnt got=%0d exp=0", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL branch_after got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
  endtask

  task automatic test_mem_wait;
    do_reset();
    step(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1); // sw
    bubble(1'b0, 1'b1);
    bubble(1'b0, 1'b0); // store in M, memory busy
    total_cnt++;
    if (ctrl !== C_FRZ) $display("FAIL mem_wait_c1 got=%b exp=%b", ctrl, C_FRZ);
    else pass_cnt++;
    bubble(1'b1, 1'b0); // branch during freeze is ignored
    total_cnt++;
    if (ctrl !== C_FRZ) $display("FAIL mem_wait_c2 got=%b exp=%b", ctrl, C_FRZ);
    else pass_cnt++;
    bubble(1'b1, 1'b0);
    total_cnt++;
    if (ctrl !== C_FRZ) $display("FAIL mem_wait_c3 got=%b exp=%b", ctrl, C_FRZ);
    else pass_cnt++;
    bubble(1'b1, 1'b1); // released; pending branch now acts
    total_cnt++;
    if (ctrl !== C_CH) $display("FAIL mem_release got=%b exp=%b", ctrl, C_CH);
    else pass_cnt++;
    bubble(1'b0, 1'b1);
    total_cnt++;
    if (stall_cnt !== 16'd3) $display("FAIL mem_wait_cnt got=%0d exp=3", stall_cnt);
    else pass_cnt++;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL mem_wait_after got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if (mem_err !== 1'b0) $display("FAIL mem_wait_no_err got=%b exp=0", mem_err);
    else pass_cnt++;
  endtask

  task automatic test_timeout;
    do_reset();
    step(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1); // sw
    bubble(1'b0, 1'b1);
    // 1 entry cycle + 15 wait cycles frozen
    for (int i = 0; i < 16; i++) begin
      bubble(1'b0, 1'b0);
      total_cnt++;
      if (ctrl !== C_FRZ)
        $display("FAIL timeout_frozen_%0d got=%b exp=%b", i, ctrl, C_FRZ);
      else pass_cnt++;
    end
    bubble(1'b0, 1'b0); // forced release
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL timeout_release got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    bubble(1'b0, 1'b0);
    total_cnt++;
    if (mem_err !== 1'b1) $display("FAIL timeout_err got=%b exp=1", mem_err);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd16) $display("FAIL timeout_cnt got=%0d exp=16", stall_cnt);
    else pass_cnt++;
    repeat (2) bubble(1'b0, 1'b0);
    total_cnt++;
    if (mem_err !== 1'b1) $display("FAIL timeout_err_sticky got=%b exp=1", mem_err);
    else pass_cnt++;
    // Second stuck access, then reset in the middle of the wait
    step(5'd1, 5'd2, 5'd0, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    bubble(1'b0, 1'b0);
    bubble(1'b0, 1'b0);
    total_cnt++;
    if (ctrl !== C_FRZ) $display("FAIL rewait_frozen got=%b exp=%b", ctrl, C_FRZ);
    else pass_cnt++;
    bubble(1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL midwait_rst_ctrl got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (mem_err !== 1'b0) $display("FAIL midwait_rst_err got=%b exp=0", mem_err);
    else pass_cnt++;
    total_cnt++;
    if (ctrl !== C_NONE) $display("FAIL midwait_rst_run got=%b exp=%b", ctrl, C_NONE);
    else pass_cnt++;
    total_cnt++;
    if (stall_cnt !== 16'd0) $display("FAIL midwait_rst_cnt got=%0d exp=0", stall_cnt);
    else pass_cnt++;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1;
    Rs1D = '0; Rs2D = '0; RdD = '0;
    RegWriteD = 1'b0; ResultSrcD = 2'b00; MemWriteD = 1'b0;
    PCSrcE = 1'b0; mem_ready = 1'b1;

    test_reset();
    test_forward();
    test_load_use();
    test_load_x0();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
